z80_io_frontend: RTL and testbench

// - Upstream stage of the Z80<->Wishbone mailbox: turns raw asynchronous Z80 I/O bus activity into clean clk-domain transactions.
// - Synchronises and glitch-filters IOREQ/RD/WR, decodes an address window and captures address/data.
// - Emits one single-cycle strobe per Z80 I/O cycle and drives read data back through the external transceiver.
// - Mailbox logic downstream sees only io_* strobes and never raw Z80 pins.

---
 rtl/z80_io_frontend.sv | 169 ++++++++++++++++
 tb/tb_z80_io_frontend.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_frontend.sv
// rtl/z80_io_frontend.sv - Z80 I/O front end: synchronise, glitch-filter, decode, one strobe per I/O cycle
// Optional macro Z80_WAIT_EN adds z80_wait_b, which stretches Z80 reads until the consumer supplies data.
module z80_io_frontend #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         FILTER_CYCLES = 2,
  parameter logic [7:0] ADDR_MASK     = 8'hFC,
  parameter logic [7:0] ADDR_MATCH    = 8'h80
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       z80_ioreq_b,
  input  logic       z80_read_strobe_b,
  input  logic       z80_write_strobe_b,
  input  logic       z80_m1,
  input  logic [7:0] z80_address_bus,
  input  logic [7:0] z80_data_bus_in,
  output logic [7:0] z80_data_bus_out,
  output logic       z80_bus_dir,
  output logic [7:0] io_addr,
  output logic [7:0] io_wdata,
  output logic       io_write_stb,
  output logic       io_read_stb,
  input  logic [7:0] rd_data,
  input  logic       rd_data_valid,
  output logic       proto_err,
  output logic       busy
`ifdef Z80_WAIT_EN
  ,
  output logic       z80_wait_b
`endif
);

  localparam int SW = 20;
  // Strobes idle high and M1 idles low so reset never looks like an active cycle.
  localparam logic [SW-1:0] SYNC_RST = 20'h70000;
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_WRITE,
    S_READ_REQ,
    S_READ_DRIVE,
    S_RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          qual_wr;

  logic [SW-1:0] sync_sr [SYNC_STAGES];
  logic          m1_s;
  logic          ioreq_s;
  logic          rd_s;
  logic          wr_s;
  logic [7:0]    addr_s;
  logic [7:0]    data_s;

  logic          rd_q;
  logic          wr_q;
  logic          win_hit;
  logic          hold;
  logic          accept;
  logic          acc_wr;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_sr[i] <= SYNC_RST;
    end else begin
      sync_sr[0] <= {z80_m1, z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b,
                     z80_address_bus, z80_data_bus_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_sr[i] <= sync_sr[i-1];
    end
  end

  assign {m1_s, ioreq_s, rd_s, wr_s, addr_s, data_s} = sync_sr[SYNC_STAGES-1];

  assign rd_q    = m1_s & ~ioreq_s & ~rd_s;
  assign wr_q    = m1_s & ~ioreq_s & ~wr_s;
  assign win_hit = ((addr_s & ADDR_MASK) == ADDR_MATCH);
  assign hold    = qual_wr ? (wr_q & ~rd_q) : (rd_q & ~wr_q);

  // With a one-sample filter the IDLE sample itself completes qualification.
  assign accept = ((state == S_IDLE) && (FILTER_CYCLES == 1) && (rd_q ^ wr_q)) ||
                  ((state == S_QUAL) && hold && (cnt == CW'(FILTER_CYCLES - 1)));
  assign acc_wr = (state == S_IDLE) ? wr_q : qual_wr;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state            <= S_IDLE;
      cnt              <= '0;
      qual_wr          <= 1'b0;
      io_addr          <= 8'h00;
      io_wdata         <= 8'h00;
      io_write_stb     <= 1'b0;
      io_read_stb      <= 1'b0;
      proto_err        <= 1'b0;
      z80_data_bus_out <= 8'h00;
`ifdef Z80_WAIT_EN
      z80_wait_b       <= 1'b1;
`endif
    end else begin
      io_write_stb <= 1'b0;
      io_read_stb  <= 1'b0;
      proto_err    <= 1'b0;
      if (accept) begin
        io_addr <= addr_s;
        if (acc_wr) io_wdata <= data_s;
        if (!win_hit) begin
          state <= S_RELEASE;
        end else if (acc_wr) begin
          state        <= S_WRITE;
          io_write_stb <= 1'b1;
        end else begin
          state       <= S_READ_REQ;
          io_read_stb <= 1'b1;
`ifdef Z80_WAIT_EN
          z80_wait_b  <= 1'b0;
`endif
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (rd_q && wr_q) begin
              proto_err <= 1'b1;
              state     <= S_RELEASE;
            end else if (rd_q || wr_q) begin
              qual_wr <= wr_q;
              cnt     <= CW'(1);
              state   <= S_QUAL;
            end
          end
          S_QUAL: begin
            if (!hold) state <= S_IDLE;
            else       cnt   <= cnt + 1'b1;
          end
          S_WRITE: state <= S_RELEASE;
          S_READ_REQ: begin
            if (rd_data_valid) begin
              z80_data_bus_out <= rd_data;
              state            <= S_READ_DRIVE;
`ifdef Z80_WAIT_EN
              z80_wait_b       <= 1'b1;
`endif
            end
`ifndef Z80_WAIT_EN
            else if (!rd_q) begin
              proto_err <= 1'b1;
              state     <= S_IDLE;
            end
`endif
          end
          S_READ_DRIVE: begin
            if (!rd_q) state <= S_RELEASE;
          end
          S_RELEASE: begin
            if (ioreq_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Raw RD gates the driver so the transceiver turns around without synchroniser delay.
  assign z80_bus_dir = reset_b & (state == S_READ_DRIVE) & ~z80_read_strobe_b;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_z80_io_frontend.sv
// tb/tb_z80_io_frontend.sv - randomized scoreboard bench for z80_io_frontend
module tb_z80_io_frontend;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       ioreq_b, rd_b, wr_b, m1;
  logic [7:0] addr_bus, data_in;
  logic [7:0] z80_data_bus_out;
  logic       z80_bus_dir;
  logic [7:0] io_addr, io_wdata;
  logic       io_write_stb, io_read_stb;
  logic [7:0] rd_data;
  logic       rd_data_valid;
  logic       proto_err, busy;
`ifdef Z80_WAIT_EN
  logic       z80_wait_b;
`endif

  z80_io_frontend dut (
    .clk(clk),
    .reset_b(reset_b),
    .z80_ioreq_b(ioreq_b),
    .z80_read_strobe_b(rd_b),
    .z80_write_strobe_b(wr_b),
    .z80_m1(m1),
    .z80_address_bus(addr_bus),
    .z80_data_bus_in(data_in),
    .z80_data_bus_out(z80_data_bus_out),
    .z80_bus_dir(z80_bus_dir),
    .io_addr(io_addr),
    .io_wdata(io_wdata),
    .io_write_stb(io_write_stb),
    .io_read_stb(io_read_stb),
    .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .proto_err(proto_err),
    .busy(busy)
`ifdef Z80_WAIT_EN
    ,
    .z80_wait_b(z80_wait_b)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_WR = 1, K_RD = 2, K_PERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         t0;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         resp_en  = 0;
  bit         fixed_en = 0;
  logic [7:0] fixed_data = 8'h00;
  logic [7:0] last_rdata = 8'h00;
  bit         drive_ok = 0;
  bit         bad_drive = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    int  lat;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, 0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != K_PERR && e.kind == kind) begin
        lat = cyc - e.t0;
        check("io_addr", int'(io_addr), int'(e.addr));
        check("strobe_latency_4to5", int'(lat >= 4 && lat <= 5), 1);
        if (kind == K_WR) check("io_wdata", int'(io_wdata), int'(e.data));
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_b) begin
      if (io_write_stb) observe(K_WR);
      if (io_read_stb)  observe(K_RD);
      if (proto_err)    observe(K_PERR);
      if (z80_bus_dir && !drive_ok) bad_drive = 1;
    end
  end

  // Consumer model: answers read requests after 0..2 cycles
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (reset_b && io_read_stb && resp_en) begin
        d = fixed_en ? 0 : $urandom_range(0, 2);
        repeat (d) @(negedge clk);
        last_rdata    = fixed_en ? fixed_data : 8'($urandom);
        rd_data       = last_rdata;
        rd_data_valid = 1'b1;
        @(posedge clk);
        #1;
        rd_data_valid = 1'b0;
        rd_data       = 8'($urandom);
      end
    end
  end

  // kind: 0 write, 1 read, 2 glitch, 3 RD+WR together, 4 INTACK, 5 read abandoned early
  task automatic txn(input int kind, input logic [7:0] a, input logic [7:0] d);
    bit  inwin;
    ev_t e;
    inwin  = ((a & 8'hFC) == 8'h80);
    bad_drive = 0;
    @(posedge clk);
    #1;
    e.addr = a;
    e.data = d;
    e.t0   = cyc;
    addr_bus = a;
    data_in  = d;
    case (kind)
      0: begin
        if (inwin) begin e.kind = K_WR; exp_q.push_back(e); end
        ioreq_b = 0; wr_b = 0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_during_write", int'(busy), 1);
        ioreq_b = 1; wr_b = 1;
      end
      1: begin
        if (inwin) begin e.kind = K_RD; exp_q.push_back(e); end
        resp_en  = 1;
        drive_ok = inwin;
        ioreq_b = 0; rd_b = 0;
        repeat (10) @(posedge clk);
        #1;
        check("bus_dir_while_rd_low", int'(z80_bus_dir), int'(inwin));
        if (inwin) check("read_data_out", int'(z80_data_bus_out), int'(last_rdata));
        ioreq_b = 1; rd_b = 1;
        #1;
        check("bus_dir_off_on_rd_rise", int'(z80_bus_dir), 0);
        drive_ok = 0;
      end
      2: begin
        ioreq_b = 0; wr_b = 0;
        @(posedge clk);
        #1;
        ioreq_b = 1; wr_b = 1;
      end
      3: begin
        e.kind = K_PERR; exp_q.push_back(e);
        ioreq_b = 0; rd_b = 0; wr_b = 0;
        repeat (6) @(posedge clk);
        #1;
        check("busy_after_collision", int'(busy), 1);
        ioreq_b = 1; rd_b = 1; wr_b = 1;
      end
      4: begin
        m1 = 0; ioreq_b = 0; rd_b = 0;
        repeat (6) @(posedge clk);
        #1;
        check("busy_intack", int'(busy), 0);
        ioreq_b = 1; rd_b = 1; m1 = 1;
      end
      default: begin
        if (inwin) begin
          e.kind = K_RD;   exp_q.push_back(e);
          e.kind = K_PERR; exp_q.push_back(e);
        end
        resp_en = 0;
        ioreq_b = 0; rd_b = 0;
        repeat (8) @(posedge clk);
        #1;
        ioreq_b = 1; rd_b = 1;
      end
    endcase
    repeat (6) @(posedge clk);
    #1;
    resp_en = 0;
    check("idle_after_cycle", int'(busy), 0);
    check("no_stray_bus_drive", int'(bad_drive), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int         k;
    logic [7:0] a;
    reset_b = 0; ioreq_b = 1; rd_b = 1; wr_b = 1; m1 = 1;
    addr_bus = 8'h00; data_in = 8'h00; rd_data = 8'h00; rd_data_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", int'(z80_data_bus_out), 0);
    check("rst_bus_dir", int'(z80_bus_dir), 0);
    check("rst_io_addr", int'(io_addr), 0);
    check("rst_io_wdata", int'(io_wdata), 0);
    check("rst_strobes", int'({io_write_stb, io_read_stb, proto_err}), 0);
    check("rst_busy", int'(busy), 0);
    reset_b = 1;
    repeat (3) @(posedge clk);

    txn(0, 8'h81, 8'h5A);
    fixed_en = 1; fixed_data = 8'hC3;
    txn(1, 8'h80, 8'h00);
    fixed_en = 0;
    txn(2, 8'h80, 8'h11);
    txn(0, 8'h10, 8'h22);
    txn(3, 8'h82, 8'h33);
    txn(0, 8'h83, 8'hA5);
`ifndef Z80_WAIT_EN
    txn(5, 8'h80, 8'h00);
`endif

    for (int i = 0; i < 60; i++) begin
`ifdef Z80_WAIT_EN
      k = $urandom_range(0, 4);
`else
      k = $urandom_range(0, 5);
`endif
      if ($urandom_range(0, 3) != 0) a = 8'h80 | 8'($urandom_range(0, 3));
      else                           a = 8'($urandom);
      txn(k, a, 8'($urandom));
    end

    // Reset while the bus is being driven
    begin
      ev_t e;
      @(posedge clk);
      #1;
      e.kind = K_RD; e.addr = 8'h81; e.data = 8'h00; e.t0 = cyc;
      exp_q.push_back(e);
      addr_bus = 8'h81; resp_en = 1; drive_ok = 1;
      ioreq_b = 0; rd_b = 0;
      repeat (9) @(posedge clk);
      #1;
      check("bus_dir_before_reset", int'(z80_bus_dir), 1);
      reset_b = 0;
      #1;
      check("bus_dir_async_reset", int'(z80_bus_dir), 0);
      check("data_out_async_reset", int'(z80_data_bus_out), 0);
      check("io_addr_async_reset", int'(io_addr), 0);
      @(posedge clk);
      #1;
      ioreq_b = 1; rd_b = 1; resp_en = 0; drive_ok = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_b = 1;
      repeat (4) @(posedge clk);
      #1;
      check("busy_after_reset", int'(busy), 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
